// File: rtl/exe_stage.sv
// EXE pipeline stage: operand select, ALU, iterative shift-add multiplier and the
// EXE/MEM boundary register. A MUL holds upstream through stall_exe until its product is ready.
module exe_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_exe,
  input  logic        flush_exe,
  input  logic        wrf_exe,
  input  logic        aludc_exe,
  input  logic        wdc_exe,
  input  logic        wdmem_exe,
  input  logic [3:0]  aluc_exe,
  input  logic        immc_exe,
  input  logic        shift_exe,
  input  logic [31:0] pc8_exe,
  input  logic [31:0] rd1_exe,
  input  logic [31:0] shamt32_exe,
  input  logic [31:0] rd2_exe,
  input  logic [31:0] imm32_exe,
  input  logic [4:0]  wa_exe,
  output logic        stall_exe,
  output logic        valid_mem,
  output logic        wrf_mem,
  output logic        wdc_mem,
  output logic        wdmem_mem,
  output logic [31:0] alur_mem,
  output logic [31:0] rd2_mem,
  output logic [4:0]  wa_mem
);

  localparam int         MUL_CYCLES = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT   = 5'(MUL_CYCLES - 1);
  localparam logic [3:0] OP_MUL     = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] opa_s, opb_s, alu_s, res_s;
  logic [31:0] mul_a_r, mul_b_r, acc_r, rd2_hold_r;
  logic [4:0]  cnt_r, wa_hold_r;
  logic        wrf_hold_r, wdc_hold_r, wdmem_hold_r;
  logic        mul_start_s, stall_s, load_s, step_s, cap_s, cap_mul_s;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b0110: r = {31'b0, ($signed(a) < $signed(b))};
      4'b0111: r = {31'b0, (a < b)};
      4'b1000: r = b << a[4:0];
      4'b1001: r = b >> a[4:0];
      4'b1010: r = $unsigned($signed(b) >>> a[4:0]);
      4'b1011: r = {b[15:0], 16'b0};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Partial product for the multiplier bits retired this cycle (operands pre-shifted by the caller).
  function automatic logic [31:0] mul_partial(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum;
    sum = 32'h0000_0000;
    for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      sum = sum + (a[i] ? (b << i) : 32'h0000_0000);
    end
    return sum;
  endfunction

  assign opa_s       = shift_exe ? shamt32_exe : rd1_exe;
  assign opb_s       = immc_exe ? imm32_exe : rd2_exe;
  assign alu_s       = alu_fn(aluc_exe, opa_s, opb_s);
  assign res_s       = aludc_exe ? pc8_exe : alu_s;
  assign mul_start_s = valid_exe & ~flush_exe & ~aludc_exe & (aluc_exe == OP_MUL);
  assign stall_exe   = stall_s & rst;

  // Next-state and capture decisions; flush outranks every other condition.
  always_comb begin
    state_s   = state_r;
    stall_s   = 1'b0;
    load_s    = 1'b0;
    step_s    = 1'b0;
    cap_s     = 1'b0;
    cap_mul_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush_exe) begin
          state_s = IDLE;
        end else if (mul_start_s) begin
          stall_s = 1'b1;
          load_s  = 1'b1;
          state_s = BUSY;
        end else if (valid_exe) begin
          cap_s = 1'b1;
        end else begin
          cap_s = 1'b0;
        end
      end
      BUSY: begin
        if (flush_exe) begin
          state_s = IDLE;
        end else begin
          stall_s = 1'b1;
          step_s  = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_s = DONE;
          end else begin
            state_s = BUSY;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
        if (flush_exe) begin
          cap_mul_s = 1'b0;
        end else begin
          cap_mul_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state, multiplier datapath and the control fields held for the MUL result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      mul_a_r      <= 32'h0000_0000;
      mul_b_r      <= 32'h0000_0000;
      acc_r        <= 32'h0000_0000;
      cnt_r        <= 5'd0;
      rd2_hold_r   <= 32'h0000_0000;
      wa_hold_r    <= 5'd0;
      wrf_hold_r   <= 1'b0;
      wdc_hold_r   <= 1'b0;
      wdmem_hold_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        mul_a_r      <= opa_s;
        mul_b_r      <= opb_s;
        acc_r        <= 32'h0000_0000;
        cnt_r        <= 5'd0;
        rd2_hold_r   <= rd2_exe;
        wa_hold_r    <= wa_exe;
        wrf_hold_r   <= wrf_exe;
        wdc_hold_r   <= wdc_exe;
        wdmem_hold_r <= wdmem_exe;
      end else if (step_s) begin
        acc_r   <= acc_r + mul_partial(mul_a_r, mul_b_r);
        mul_a_r <= mul_a_r >> MUL_BITS_PER_CYCLE;
        mul_b_r <= mul_b_r << MUL_BITS_PER_CYCLE;
        cnt_r   <= cnt_r + 5'd1;
      end
    end
  end

  // EXE/MEM boundary register; anything not captured becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_mem <= 1'b0;
      wrf_mem   <= 1'b0;
      wdc_mem   <= 1'b0;
      wdmem_mem <= 1'b0;
      alur_mem  <= 32'h0000_0000;
      rd2_mem   <= 32'h0000_0000;
      wa_mem    <= 5'd0;
    end else if (cap_mul_s) begin
      valid_mem <= 1'b1;
      wrf_mem   <= wrf_hold_r;
      wdc_mem   <= wdc_hold_r;
      wdmem_mem <= wdmem_hold_r;
      alur_mem  <= acc_r;
      rd2_mem   <= rd2_hold_r;
      wa_mem    <= wa_hold_r;
    end else if (cap_s) begin
      valid_mem <= 1'b1;
      wrf_mem   <= wrf_exe;
      wdc_mem   <= wdc_exe;
      wdmem_mem <= wdmem_exe;
      alur_mem  <= res_s;
      rd2_mem   <= rd2_exe;
      wa_mem    <= wa_exe;
    end else begin
      valid_mem <= 1'b0;
      wrf_mem   <= 1'b0;
      wdc_mem   <= 1'b0;
      wdmem_mem <= 1'b0;
      alur_mem  <= 32'h0000_0000;
      rd2_mem   <= 32'h0000_0000;
      wa_mem    <= 5'd0;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: two instances (1 and 4 multiplier bits per cycle) share stimulus and
// are checked every cycle against a transaction-level model, plus literal expectations.
module tb_exe_stage;

  typedef struct packed {
    logic        v;
    logic        wrf;
    logic        wdc;
    logic        wdmem;
    logic [31:0] alur;
    logic [31:0] rd2;
    logic [4:0]  wa;
  } mem_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sh;
    logic        im;
    logic [31:0] e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_exe, flush_exe, wrf_exe, aludc_exe, wdc_exe, wdmem_exe, immc_exe, shift_exe;
  logic [3:0]  aluc_exe;
  logic [31:0] pc8_exe, rd1_exe, shamt32_exe, rd2_exe, imm32_exe;
  logic [4:0]  wa_exe;

  logic        stall_o [2];
  logic        valid_o [2];
  logic        wrf_o   [2];
  logic        wdc_o   [2];
  logic        wdmem_o [2];
  logic [31:0] alur_o  [2];
  logic [31:0] rd2_o   [2];
  logic [4:0]  wa_o    [2];

  int          total = 0;
  int          bad   = 0;
  int          left    [2];
  logic [31:0] mres    [2];
  mem_t        held    [2];
  mem_t        exp_mem [2];

  always #5 clk = ~clk;

  exe_stage #(.MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .valid_exe(valid_exe), .flush_exe(flush_exe), .wrf_exe(wrf_exe),
    .aludc_exe(aludc_exe), .wdc_exe(wdc_exe), .wdmem_exe(wdmem_exe), .aluc_exe(aluc_exe),
    .immc_exe(immc_exe), .shift_exe(shift_exe), .pc8_exe(pc8_exe), .rd1_exe(rd1_exe),
    .shamt32_exe(shamt32_exe), .rd2_exe(rd2_exe), .imm32_exe(imm32_exe), .wa_exe(wa_exe),
    .stall_exe(stall_o[0]), .valid_mem(valid_o[0]), .wrf_mem(wrf_o[0]), .wdc_mem(wdc_o[0]),
    .wdmem_mem(wdmem_o[0]), .alur_mem(alur_o[0]), .rd2_mem(rd2_o[0]), .wa_mem(wa_o[0]));

  exe_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .valid_exe(valid_exe), .flush_exe(flush_exe), .wrf_exe(wrf_exe),
    .aludc_exe(aludc_exe), .wdc_exe(wdc_exe), .wdmem_exe(wdmem_exe), .aluc_exe(aluc_exe),
    .immc_exe(immc_exe), .shift_exe(shift_exe), .pc8_exe(pc8_exe), .rd1_exe(rd1_exe),
    .shamt32_exe(shamt32_exe), .rd2_exe(rd2_exe), .imm32_exe(imm32_exe), .wa_exe(wa_exe),
    .stall_exe(stall_o[1]), .valid_mem(valid_o[1]), .wrf_mem(wrf_o[1]), .wdc_mem(wdc_o[1]),
    .wdmem_mem(wdmem_o[1]), .alur_mem(alur_o[1]), .rd2_mem(rd2_o[1]), .wa_mem(wa_o[1]));

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] s;
    s = a[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return b << s;
      4'd9:    return b >> s;
      4'd10:   return $unsigned($signed(b) >>> s);
      4'd11:   return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic mem_t actual(input int j);
    mem_t m;
    m = '{valid_o[j], wrf_o[j], wdc_o[j], wdmem_o[j], alur_o[j], rd2_o[j], wa_o[j]};
    return m;
  endfunction

  task automatic check_mem(input string nm, input mem_t a, input mem_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got v=%0d wrf=%0d wdc=%0d wdm=%0d alur=%h rd2=%h wa=%0d, required v=%0d wrf=%0d wdc=%0d wdm=%0d alur=%h rd2=%h wa=%0d",
               nm, a.v, a.wrf, a.wdc, a.wdmem, a.alur, a.rd2, a.wa,
               e.v, e.wrf, e.wdc, e.wdmem, e.alur, e.rd2, e.wa);
    end
  endtask

  task automatic check1(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask

  // Per-cycle compare against the model: outputs from the last edge, stall for the current inputs.
  always @(negedge clk) begin
    logic [31:0] opa, opb;
    mem_t        nx;
    logic        es;
    int          mc;
    for (int j = 0; j < 2; j++) begin
      if (!rst) begin
        left[j]    = 0;
        exp_mem[j] = '0;
      end
      check_mem($sformatf("mem%0d@%0t", j, $time), actual(j), exp_mem[j]);
      mc  = (j == 0) ? 32 : 8;
      nx  = '0;
      es  = 1'b0;
      opa = shift_exe ? shamt32_exe : rd1_exe;
      opb = immc_exe ? imm32_exe : rd2_exe;
      if (!rst) begin
        es = 1'b0;
      end else if (flush_exe) begin
        left[j] = 0;
      end else if (left[j] == 1) begin
        nx      = held[j];
        nx.alur = mres[j];
        left[j] = 0;
      end else if (left[j] > 1) begin
        es      = 1'b1;
        left[j] = left[j] - 1;
      end else if (valid_exe && aluc_exe == 4'b1100 && !aludc_exe) begin
        es      = 1'b1;
        left[j] = mc + 1;
        mres[j] = opa * opb;
        held[j] = '{1'b1, wrf_exe, wdc_exe, wdmem_exe, 32'd0, rd2_exe, wa_exe};
      end else if (valid_exe) begin
        nx = '{1'b1, wrf_exe, wdc_exe, wdmem_exe,
               aludc_exe ? pc8_exe : alu_ref(aluc_exe, opa, opb), rd2_exe, wa_exe};
      end
      check1($sformatf("stall%0d@%0t", j, $time), {31'd0, stall_o[j]}, {31'd0, es});
      exp_mem[j] = nx;
    end
  end

  task automatic nop();
    valid_exe = 1'b0; flush_exe = 1'b0; wrf_exe = 1'b0; aludc_exe = 1'b0; wdc_exe = 1'b0;
    wdmem_exe = 1'b0; immc_exe = 1'b0; shift_exe = 1'b0; aluc_exe = 4'd0; pc8_exe = 32'd0;
    rd1_exe = 32'd0; shamt32_exe = 32'd0; rd2_exe = 32'd0; imm32_exe = 32'd0; wa_exe = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    nop();
    valid_exe = 1'b1; wrf_exe = 1'b1; wdc_exe = 1'b1; aluc_exe = op;
    rd1_exe = a; rd2_exe = b; wa_exe = 5'd9;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [12];
    int   n0, n1;
    bit   done0, done1;
    vecs[0]  = '{4'b0001, 32'd5, 32'd7, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[1]  = '{4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 32'h0000_F000};
    vecs[2]  = '{4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 32'h0000_FFF0};
    vecs[3]  = '{4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 32'h0000_0FF0};
    vecs[4]  = '{4'b0101, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[5]  = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001};
    vecs[6]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000};
    vecs[7]  = '{4'b1000, 32'h0000_0024, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010};
    vecs[8]  = '{4'b1001, 32'h0000_0004, 32'h8000_0000, 1'b0, 1'b0, 32'h0800_0000};
    vecs[9]  = '{4'b1010, 32'h0000_0004, 32'h8000_0000, 1'b1, 1'b0, 32'hF800_0000};
    vecs[10] = '{4'b1011, 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b1, 32'h1234_0000};
    vecs[11] = '{4'b1101, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0000};

    rst = 1'b0;
    nop();
    #3;
    check1("reset_valid", {31'd0, valid_o[0]}, 32'd0);
    check1("reset_alur", alur_o[0], 32'd0);
    check1("reset_stall", {31'd0, stall_o[0]}, 32'd0);
    tick();
    tick();
    rst = 1'b1;

    set_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    check1("add_alur", alur_o[0], 32'h8000_0000);
    check1("add_valid", {31'd0, valid_o[0]}, 32'd1);
    check1("add_stall", {31'd0, stall_o[0]}, 32'd0);

    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b);
      shift_exe = vecs[i].sh;
      shamt32_exe = vecs[i].a;
      immc_exe = vecs[i].im;
      imm32_exe = vecs[i].b;
      if (vecs[i].im) rd2_exe = 32'hDEAD_BEEF;
      if (vecs[i].sh) rd1_exe = 32'h0000_001F;
      tick();
      check1($sformatf("op%b", vecs[i].op), alur_o[0], vecs[i].e);
    end

    // Link overrides the ALU, even with the MUL opcode.
    set_op(4'b1100, 32'd6, 32'd7);
    aludc_exe = 1'b1; pc8_exe = 32'h0040_0010; wa_exe = 5'd31;
    #1;
    check1("link_stall", {31'd0, stall_o[0]}, 32'd0);
    tick();
    check1("link_alur", alur_o[0], 32'h0040_0010);
    check1("link_wa", {27'd0, wa_o[0]}, 32'd31);
    nop();
    tick();

    // Full multiply; instance 4 finishes first and restarts on the held instruction.
    set_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0003);
    wdmem_exe = 1'b1; wa_exe = 5'd17;
    n0 = 0; n1 = 0; done0 = 1'b0; done1 = 1'b0;
    for (int c = 0; c < 60 && !done0; c++) begin
      @(negedge clk);
      if (!done1) begin
        if (stall_o[1]) n1++;
        else done1 = 1'b1;
      end
      if (stall_o[0]) n0++;
      else done0 = 1'b1;
    end
    check1("mul_stall_cycles_1", n0, 32'd33);
    check1("mul_stall_cycles_4", n1, 32'd9);
    @(posedge clk);
    #1;
    check1("mul_alur", alur_o[0], 32'hFFFF_FFFD);
    check1("mul_valid", {31'd0, valid_o[0]}, 32'd1);
    check1("mul_wa", {27'd0, wa_o[0]}, 32'd17);
    nop();
    repeat (25) tick();

    // Flush in the tenth busy cycle.
    set_op(4'b1100, 32'd6, 32'd7);
    tick();
    repeat (9) tick();
    flush_exe = 1'b1;
    #1;
    check1("flush_stall", {31'd0, stall_o[0]}, 32'd0);
    tick();
    set_op(4'b0000, 32'd10, 32'd20);
    check1("flush_bubble", {31'd0, valid_o[0]}, 32'd0);
    tick();
    check1("post_flush_add", alur_o[0], 32'd30);
    nop();
    tick();

    // Asynchronous reset in the fifth busy cycle.
    set_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0003);
    tick();
    repeat (4) tick();
    #1;
    rst = 1'b0;
    #1;
    check1("rst_mid_stall", {31'd0, stall_o[0]}, 32'd0);
    check1("rst_mid_stall4", {31'd0, stall_o[1]}, 32'd0);
    check_mem("rst_mid_mem", actual(0), '0);
    nop();
    tick();
    tick();
    rst = 1'b1;
    set_op(4'b0000, 32'd2, 32'd3);
    tick();
    check1("post_rst_add", alur_o[0], 32'd5);
    check1("post_rst_add4", alur_o[1], 32'd5);
    nop();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
